// File: rtl/basketball_game_timer.sv
// basketball_game_timer
// Game clock (M:SS, BCD) and shot clock (SS, BCD) controller for the
// scoreboard. One game second elapses per rising edge of the 1 Hz divider
// output, sampled on the 50 MHz system clock.
//
// Ports:
//   clock_in        50 MHz system clock, rising edge
//   reset           asynchronous, active-high
//   tick_1hz_in     1 Hz square wave (asynchronous phase)
//   start_pause     one-cycle pulse, toggles run/pause
//   shot_reset      one-cycle pulse, reloads the shot clock
//   next_period     one-cycle pulse, leaves period end
//   min_out         minutes, binary 0..10
//   sec_tens_out    seconds tens digit 0..5
//   sec_units_out   seconds units digit 0..9
//   shot_tens_out   shot clock tens digit
//   shot_units_out  shot clock units digit
//   period_out      current period 1..NUM_PERIODS
//   running         high while the clocks run
//   shot_violation  one-cycle pulse when the shot clock expires
//   period_end      one-cycle pulse when the game clock expires
//   game_over       level, high once the last period has ended
module basketball_game_timer #(
   parameter int PERIOD_MINUTES = 10,
   parameter int NUM_PERIODS    = 4,
   parameter int SHOT_SECONDS   = 24
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       tick_1hz_in,
   input  logic       start_pause,
   input  logic       shot_reset,
   input  logic       next_period,
   output logic [3:0] min_out,
   output logic [2:0] sec_tens_out,
   output logic [3:0] sec_units_out,
   output logic [2:0] shot_tens_out,
   output logic [3:0] shot_units_out,
   output logic [2:0] period_out,
   output logic       running,
   output logic       shot_violation,
   output logic       period_end,
   output logic       game_over
);

   localparam logic [3:0] MIN_LOAD        = 4'(PERIOD_MINUTES);
   localparam logic [2:0] SHOT_TENS_LOAD  = 3'(SHOT_SECONDS / 10);
   localparam logic [3:0] SHOT_UNITS_LOAD = 4'(SHOT_SECONDS % 10);
   localparam logic [2:0] LAST_PERIOD     = 3'(NUM_PERIODS);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RUNNING    = 3'd1,
      ST_PAUSED     = 3'd2,
      ST_PERIOD_END = 3'd3,
      ST_GAME_OVER  = 3'd4
   } state_t;

   state_t state_r;
   state_t state_nxt;

   logic s1_r;
   logic s2_r;
   logic s3_r;
   logic tick_s;

   logic [10:0] game_dec_s;
   logic [6:0]  shot_dec_s;
   logic        game_last_s;
   logic        shot_last_s;

   logic [3:0] min_nxt;
   logic [2:0] sec_tens_nxt;
   logic [3:0] sec_units_nxt;
   logic [2:0] shot_tens_nxt;
   logic [3:0] shot_units_nxt;
   logic [2:0] period_nxt;
   logic       shot_violation_nxt;
   logic       period_end_nxt;

   // Saturating BCD decrement of M:SS, returned as {min, tens, units}.
   function automatic logic [10:0] dec_game(input logic [3:0] m,
                                            input logic [2:0] t,
                                            input logic [3:0] u);
      logic [10:0] r;
      if (u != 4'd0) begin
         r = {m, t, u - 4'd1};
      end else if (t != 3'd0) begin
         r = {m, t - 3'd1, 4'd9};
      end else if (m != 4'd0) begin
         r = {m - 4'd1, 3'd5, 4'd9};
      end else begin
         r = {m, t, u};
      end
      return r;
   endfunction

   // Saturating BCD decrement of SS, returned as {tens, units}.
   function automatic logic [6:0] dec_shot(input logic [2:0] t,
                                           input logic [3:0] u);
      logic [6:0] r;
      if (u != 4'd0) begin
         r = {t, u - 4'd1};
      end else if (t != 3'd0) begin
         r = {t - 3'd1, 4'd9};
      end else begin
         r = {t, u};
      end
      return r;
   endfunction

   // Synchronise the 1 Hz wave and keep one extra stage for edge detection.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= tick_1hz_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // A held-high input yields s2 = s3 = 1, so only one tick per rising edge.
   assign tick_s = s2_r & ~s3_r;

   assign game_dec_s  = dec_game(min_out, sec_tens_out, sec_units_out);
   assign shot_dec_s  = dec_shot(shot_tens_out, shot_units_out);
   // "Last second" means this tick takes the clock to zero.
   assign game_last_s = (min_out == 4'd0) && (sec_tens_out == 3'd0) &&
                        (sec_units_out == 4'd1);
   assign shot_last_s = (shot_tens_out == 3'd0) && (shot_units_out == 4'd1);

   // Next-state and next-counter logic.
   always_comb begin
      state_nxt          = state_r;
      min_nxt            = min_out;
      sec_tens_nxt       = sec_tens_out;
      sec_units_nxt      = sec_units_out;
      shot_tens_nxt      = shot_tens_out;
      shot_units_nxt     = shot_units_out;
      period_nxt         = period_out;
      shot_violation_nxt = 1'b0;
      period_end_nxt     = 1'b0;

      case (state_r)
         ST_IDLE, ST_PAUSED: begin
            if (shot_reset) begin
               shot_tens_nxt  = SHOT_TENS_LOAD;
               shot_units_nxt = SHOT_UNITS_LOAD;
            end else begin
               shot_tens_nxt  = shot_tens_out;
               shot_units_nxt = shot_units_out;
            end
            if (start_pause) begin
               state_nxt = ST_RUNNING;
            end else begin
               state_nxt = state_r;
            end
         end

         ST_RUNNING: begin
            // start_pause and shot_reset both take priority over a tick.
            if (start_pause || shot_reset) begin
               if (shot_reset) begin
                  shot_tens_nxt  = SHOT_TENS_LOAD;
                  shot_units_nxt = SHOT_UNITS_LOAD;
               end else begin
                  shot_tens_nxt  = shot_tens_out;
                  shot_units_nxt = shot_units_out;
               end
               if (start_pause) begin
                  state_nxt = ST_PAUSED;
               end else begin
                  state_nxt = ST_RUNNING;
               end
            end else if (tick_s) begin
               {min_nxt, sec_tens_nxt, sec_units_nxt} = game_dec_s;
               {shot_tens_nxt, shot_units_nxt}        = shot_dec_s;
               // Period end wins over a simultaneous shot expiry.
               if (game_last_s) begin
                  period_end_nxt = 1'b1;
                  if (period_out < LAST_PERIOD) begin
                     state_nxt = ST_PERIOD_END;
                  end else begin
                     state_nxt = ST_GAME_OVER;
                  end
               end else if (shot_last_s) begin
                  shot_violation_nxt = 1'b1;
                  state_nxt          = ST_PAUSED;
               end else begin
                  state_nxt = ST_RUNNING;
               end
            end else begin
               state_nxt = ST_RUNNING;
            end
         end

         ST_PERIOD_END: begin
            if (next_period && (period_out < LAST_PERIOD)) begin
               period_nxt     = period_out + 3'd1;
               min_nxt        = MIN_LOAD;
               sec_tens_nxt   = 3'd0;
               sec_units_nxt  = 4'd0;
               shot_tens_nxt  = SHOT_TENS_LOAD;
               shot_units_nxt = SHOT_UNITS_LOAD;
               state_nxt      = ST_IDLE;
            end else begin
               state_nxt = ST_PERIOD_END;
            end
         end

         ST_GAME_OVER: begin
            state_nxt = ST_GAME_OVER;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         min_out        <= MIN_LOAD;
         sec_tens_out   <= 3'd0;
         sec_units_out  <= 4'd0;
         shot_tens_out  <= SHOT_TENS_LOAD;
         shot_units_out <= SHOT_UNITS_LOAD;
         period_out     <= 3'd1;
         running        <= 1'b0;
         shot_violation <= 1'b0;
         period_end     <= 1'b0;
         game_over      <= 1'b0;
      end else begin
         state_r        <= state_nxt;
         min_out        <= min_nxt;
         sec_tens_out   <= sec_tens_nxt;
         sec_units_out  <= sec_units_nxt;
         shot_tens_out  <= shot_tens_nxt;
         shot_units_out <= shot_units_nxt;
         period_out     <= period_nxt;
         running        <= (state_nxt == ST_RUNNING);
         shot_violation <= shot_violation_nxt;
         period_end     <= period_end_nxt;
         game_over      <= (state_nxt == ST_GAME_OVER);
      end
   end

endmodule

// File: tb/tb_basketball_game_timer.sv
// Self-checking bench for basketball_game_timer: directed scenarios plus
// randomized stimulus, compared every cycle with a seconds-based model.
module tb_basketball_game_timer;

   localparam int PM = 2;
   localparam int NP = 3;
   localparam int SS = 24;

   localparam int MODE_IDLE  = 0;
   localparam int MODE_RUN   = 1;
   localparam int MODE_PAUSE = 2;
   localparam int MODE_PEND  = 3;
   localparam int MODE_OVER  = 4;

   logic       clock_in = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1hz_in = 1'b0;
   logic       start_pause = 1'b0;
   logic       shot_reset = 1'b0;
   logic       next_period = 1'b0;
   logic [3:0] min_out;
   logic [2:0] sec_tens_out;
   logic [3:0] sec_units_out;
   logic [2:0] shot_tens_out;
   logic [3:0] shot_units_out;
   logic [2:0] period_out;
   logic       running;
   logic       shot_violation;
   logic       period_end;
   logic       game_over;

   basketball_game_timer #(
      .PERIOD_MINUTES(PM),
      .NUM_PERIODS(NP),
      .SHOT_SECONDS(SS)
   ) dut (
      .clock_in(clock_in),
      .reset(reset),
      .tick_1hz_in(tick_1hz_in),
      .start_pause(start_pause),
      .shot_reset(shot_reset),
      .next_period(next_period),
      .min_out(min_out),
      .sec_tens_out(sec_tens_out),
      .sec_units_out(sec_units_out),
      .shot_tens_out(shot_tens_out),
      .shot_units_out(shot_units_out),
      .period_out(period_out),
      .running(running),
      .shot_violation(shot_violation),
      .period_end(period_end),
      .game_over(game_over)
   );

   always #5 clock_in = ~clock_in;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: game time in whole seconds, shot time in seconds.
   int m_game;
   int m_shot;
   int m_period;
   int m_mode;
   bit m_pe;
   bit m_sv;
   bit h1, h2, h3;   // input as sampled 1, 2 and 3 edges ago

   logic tk_lvl = 1'b0;
   int   tk_left = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_game   = PM * 60;
      m_shot   = SS;
      m_period = 1;
      m_mode   = MODE_IDLE;
      m_pe     = 1'b0;
      m_sv     = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
   endtask

   // One clock edge of the game rules, using the inputs present at that edge.
   task automatic model_step();
      bit tk;
      int g_before;
      int s_before;
      tk = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = tick_1hz_in;
      m_pe = 1'b0;
      m_sv = 1'b0;
      case (m_mode)
         MODE_IDLE, MODE_PAUSE: begin
            if (shot_reset) m_shot = SS;
            if (start_pause) m_mode = MODE_RUN;
         end
         MODE_RUN: begin
            if (start_pause || shot_reset) begin
               if (shot_reset) m_shot = SS;
               if (start_pause) m_mode = MODE_PAUSE;
            end else if (tk) begin
               g_before = m_game;
               s_before = m_shot;
               m_game = (m_game > 0) ? m_game - 1 : 0;
               m_shot = (m_shot > 0) ? m_shot - 1 : 0;
               if (g_before > 0 && m_game == 0) begin
                  m_pe   = 1'b1;
                  m_mode = (m_period < NP) ? MODE_PEND : MODE_OVER;
               end else if (s_before > 0 && m_shot == 0) begin
                  m_sv   = 1'b1;
                  m_mode = MODE_PAUSE;
               end
            end
         end
         MODE_PEND: begin
            if (next_period && m_period < NP) begin
               m_period++;
               m_game = PM * 60;
               m_shot = SS;
               m_mode = MODE_IDLE;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_outputs();
      check_eq("min",        32'(min_out),        32'(m_game / 60));
      check_eq("sec_tens",   32'(sec_tens_out),   32'((m_game % 60) / 10));
      check_eq("sec_units",  32'(sec_units_out),  32'(m_game % 10));
      check_eq("shot_tens",  32'(shot_tens_out),  32'(m_shot / 10));
      check_eq("shot_units", 32'(shot_units_out), 32'(m_shot % 10));
      check_eq("period",     32'(period_out),     32'(m_period));
      check_eq("running",    32'(running),        32'(m_mode == MODE_RUN));
      check_eq("shot_viol",  32'(shot_violation), 32'(m_sv));
      check_eq("period_end", 32'(period_end),     32'(m_pe));
      check_eq("game_over",  32'(game_over),      32'(m_mode == MODE_OVER));
   endtask

   // Drive one cycle of inputs, advance the model on the edge, check after it.
   task automatic step(input logic tk, input logic sp, input logic sr,
                       input logic np);
      tick_1hz_in = tk;
      start_pause = sp;
      shot_reset  = sr;
      next_period = np;
      @(posedge clock_in);
      model_step();
      @(negedge clock_in);
      check_outputs();
   endtask

   // Assert reset between clock edges and confirm it acts immediately.
   task automatic do_reset();
      start_pause = 1'b0;
      shot_reset  = 1'b0;
      next_period = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1 check_outputs();
      @(posedge clock_in);
      @(negedge clock_in);
      check_outputs();
      reset = 1'b0;
   endtask

   task automatic tick_pulses(input int n, input int hi, input int lo);
      repeat (n) begin
         repeat (hi) step(1'b1, 1'b0, 1'b0, 1'b0);
         repeat (lo) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic random_round(input int budget);
      for (int c = 0; c < budget && m_mode != MODE_OVER; c++) begin
         if (tk_left == 0) begin
            tk_lvl  = ~tk_lvl;
            tk_left = $urandom_range(1, 5);
         end
         tk_left--;
         step(tk_lvl, ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0));
      end
   endtask

   // Steer the game to its end; the bound expiring counts as a failure.
   task automatic drive_to_end();
      for (int c = 0; c < 20000 && m_mode != MODE_OVER; c++) begin
         tk_lvl = ~tk_lvl;
         step(tk_lvl, (m_mode == MODE_IDLE || m_mode == MODE_PAUSE),
              ($urandom_range(0, 29) == 0), (m_mode == MODE_PEND));
      end
      check_eq("reach_game_over", 32'(game_over), 32'd1);
      // Terminal: pulses on every input must not leave game over.
      repeat (10) step($urandom_range(0, 1) == 1, 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      model_reset();
      do_reset();

      // Ticks in IDLE change nothing.
      tick_pulses(10, 2, 2);
      // Start, three ticks, then a long-held input giving one decrement.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_pulses(3, 2, 3);
      repeat (100) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      // start_pause on the tick cycle: pause wins, tick discarded.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tick_pulses(5, 2, 2);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      // shot_reset on the tick cycle while running: reload, no decrement.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Let the shot clock expire, then ticks while paused.
      tick_pulses(27, 2, 2);
      // Resume with shot at 00: game clock runs, no further violations.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_pulses(4, 1, 2);
      // shot_reset on a tick cycle.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Run a whole game to the end.
      drive_to_end();

      // Reset in the middle of a running period.
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_pulses(6, 2, 2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();

      // Randomized games.
      for (int r = 0; r < 2; r++) begin
         tk_lvl  = 1'b0;
         tk_left = 0;
         random_round(12000);
         drive_to_end();
         do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
